cpu3_core: RTL

CPU3_CORE -- requirements
Module: cpu3_core

---
 rtl/cpu3_pkg.sv | 28 ++
 rtl/cpu3_sequencer.sv | 81 ++++++++
 rtl/cpu3_core.sv | 120 ++++++++++++
 3 files changed

// File: rtl/cpu3_pkg.sv
// Shared types for the cpu3 accumulator machine: opcode encoding, sequencer states
// and the decode helper used by the sequencer.
package cpu3_pkg;

  typedef enum logic [2:0] {
    OP_LOAD  = 3'd0,
    OP_STORE = 3'd1,
    OP_ADD   = 3'd2,
    OP_SUB   = 3'd3,
    OP_BNE   = 3'd4,
    OP_IN    = 3'd5,
    OP_OUT   = 3'd6,
    OP_HALT  = 3'd7
  } opcode_e;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_MEM_RD = 3'd2,
    ST_MEM_WR = 3'd3,
    ST_HALT   = 3'd4
  } state_e;

  function automatic logic is_rd_op(input opcode_e op);
    return (op == OP_LOAD) || (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/cpu3_sequencer.sv
// Control FSM for cpu3: walks FETCH/DECODE/MEM_RD/MEM_WR/HALT and owns the
// registered memory-request controls and the halted flag.
module cpu3_sequencer
  import cpu3_pkg::*;
(
  input  logic    clock,
  input  logic    n_reset,
  input  opcode_e op,
  input  logic    op_valid,
  input  logic    mem_ready,
  output state_e  state,
  output logic    mem_req,
  output logic    mem_we,
  output logic    halted
);

  state_e state_r;
  logic   mem_req_r;
  logic   mem_we_r;
  logic   halted_r;

  // State register with request controls registered alongside the next state
  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      state_r   <= ST_FETCH;
      mem_req_r <= 1'b1;
      mem_we_r  <= 1'b0;
      halted_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_FETCH: begin
          if (mem_ready) begin
            state_r   <= ST_DECODE;
            mem_req_r <= 1'b0;
          end
        end
        ST_DECODE: begin
          if (op_valid && is_rd_op(op)) begin
            state_r   <= ST_MEM_RD;
            mem_req_r <= 1'b1;
            mem_we_r  <= 1'b0;
          end else if (op_valid && (op == OP_STORE)) begin
            state_r   <= ST_MEM_WR;
            mem_req_r <= 1'b1;
            mem_we_r  <= 1'b1;
          end else if (op_valid && (op == OP_HALT)) begin
            state_r   <= ST_HALT;
            mem_req_r <= 1'b0;
            halted_r  <= 1'b1;
          end else begin
            state_r   <= ST_FETCH;
            mem_req_r <= 1'b1;
            mem_we_r  <= 1'b0;
          end
        end
        ST_MEM_RD, ST_MEM_WR: begin
          if (mem_ready) begin
            state_r   <= ST_FETCH;
            mem_req_r <= 1'b1;
            mem_we_r  <= 1'b0;
          end
        end
        ST_HALT: begin
          state_r <= ST_HALT;
        end
        default: begin
          state_r   <= ST_FETCH;
          mem_req_r <= 1'b1;
          mem_we_r  <= 1'b0;
          halted_r  <= 1'b0;
        end
      endcase
    end
  end

  assign state   = state_r;
  assign mem_req = mem_req_r;
  assign mem_we  = mem_we_r;
  assign halted  = halted_r;

endmodule

// File: rtl/cpu3_core.sv
// cpu3 accumulator CPU top: holds PC/IR/ACC/display and executes the datapath
// actions selected by the cpu3_sequencer state.
module cpu3_core
  import cpu3_pkg::*;
#(
  parameter int WORD_W = 8,
  parameter int OP_W   = 3
) (
  input  logic                     clock,
  input  logic                     n_reset,
  output logic                     mem_req,
  output logic                     mem_we,
  output logic [WORD_W-OP_W-1:0]   mem_addr,
  output logic [WORD_W-1:0]        mem_wdata,
  input  logic [WORD_W-1:0]        mem_rdata,
  input  logic                     mem_ready,
  input  logic [WORD_W-1:0]        switches,
  output logic [WORD_W-1:0]        display,
  output logic                     z_flag,
  output logic                     halted
);

  localparam int A_W = WORD_W - OP_W;

  if ((OP_W < 3) || (WORD_W <= OP_W)) begin : g_bad_params
    $error("cpu3_core: requires OP_W >= 3 and WORD_W > OP_W");
  end

  logic [A_W-1:0]    pc_r;
  logic [WORD_W-1:0] ir_r;
  logic [WORD_W-1:0] acc_r;
  logic [WORD_W-1:0] display_r;
  logic [OP_W-1:0]   op_raw_s;
  logic [A_W-1:0]    operand_s;
  logic              op_valid_s;
  opcode_e           op_s;
  state_e            state_s;
  logic [A_W-1:0]    mem_addr_s;

  assign op_raw_s  = ir_r[WORD_W-1 -: OP_W];
  assign operand_s = ir_r[A_W-1:0];
  assign op_s      = opcode_e'(op_raw_s[2:0]);

  // Wider opcode fields decode anything above 7 as a NOP
  if (OP_W > 3) begin : g_wide_op
    assign op_valid_s = (op_raw_s[OP_W-1:3] == {(OP_W-3){1'b0}});
  end else begin : g_narrow_op
    assign op_valid_s = 1'b1;
  end

  cpu3_sequencer u_seq (
    .clock     (clock),
    .n_reset   (n_reset),
    .op        (op_s),
    .op_valid  (op_valid_s),
    .mem_ready (mem_ready),
    .state     (state_s),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .halted    (halted)
  );

  // Address source: PC while fetching, instruction operand otherwise
  always_comb begin
    mem_addr_s = pc_r;
    if (state_s == ST_FETCH) begin
      mem_addr_s = pc_r;
    end else begin
      mem_addr_s = operand_s;
    end
  end

  // Architectural registers; updates only on completed accesses or in DECODE
  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      pc_r      <= {A_W{1'b0}};
      ir_r      <= {WORD_W{1'b0}};
      acc_r     <= {WORD_W{1'b0}};
      display_r <= {WORD_W{1'b0}};
    end else begin
      case (state_s)
        ST_FETCH: begin
          if (mem_ready) begin
            ir_r <= mem_rdata;
            pc_r <= pc_r + A_W'(1);
          end
        end
        ST_DECODE: begin
          if (op_valid_s) begin
            case (op_s)
              OP_BNE: begin
                if (acc_r != {WORD_W{1'b0}}) pc_r <= operand_s;
              end
              OP_IN:   acc_r     <= switches;
              OP_OUT:  display_r <= acc_r;
              default: ;
            endcase
          end
        end
        ST_MEM_RD: begin
          if (mem_ready) begin
            case (op_s)
              OP_LOAD: acc_r <= mem_rdata;
              OP_ADD:  acc_r <= acc_r + mem_rdata;
              OP_SUB:  acc_r <= acc_r - mem_rdata;
              default: ;
            endcase
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_addr  = mem_addr_s;
  assign mem_wdata = acc_r;
  assign display   = display_r;
  assign z_flag    = (acc_r == {WORD_W{1'b0}});

endmodule
